// File: rtl/apogee_pkg.sv
// -----------------------------------------------------------------------------
// apogee_pkg
// Shared types and constants for the Radio-86RK / Apogee tape image loader.
//   rk_state_t      : parser states
//   RK_SYNC_DEFAULT : sync marker that may lead a file and precedes the checksum
//   RK_HDR_LEN      : header length in bytes (start hi/lo, end hi/lo)
//   RK_MAX_PAD_DEF  : default number of 8'h00 padding bytes tolerated
// -----------------------------------------------------------------------------
package apogee_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    DATA,
    PAD,
    CSH,
    CSL,
    DONE,
    ERR
  } rk_state_t;

  localparam logic [7:0] RK_SYNC_DEFAULT = 8'hE6;
  localparam int         RK_HDR_LEN      = 4;
  localparam int         RK_MAX_PAD_DEF  = 4;

endpackage

// File: rtl/rk_loader_if.sv
// -----------------------------------------------------------------------------
// rk_loader_if
// Byte stream in / RAM write port out of the tape image loader.
//   in_valid, in_data        : download byte strobe and data (host -> loader)
//   mem_we, mem_addr, mem_din: one-cycle RAM write (loader -> RAM mux)
// Modports: master = download host / RAM side, slave = loader.
// -----------------------------------------------------------------------------
interface rk_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;

  modport master (output in_valid, in_data, input mem_we, mem_addr, mem_din);
  modport slave  (input in_valid, in_data, output mem_we, mem_addr, mem_din);
endinterface

// File: rtl/rk_checksum.sv
// -----------------------------------------------------------------------------
// rk_checksum
// RK tape checksum accumulator. Built only when RK_CHECKSUM_EN is defined.
//   clk_sys, reset : clock, synchronous active-high reset
//   clr            : zero the accumulator (start of a new file)
//   en             : fold byte b into the sum this cycle
//   last           : b is the final payload byte (low byte add only)
//   b              : payload byte
//   cs             : running 16-bit checksum
// -----------------------------------------------------------------------------
`ifdef RK_CHECKSUM_EN
module rk_checksum (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        last,
  input  logic [7:0]  b,
  output logic [15:0] cs
);

  logic [15:0] cs_q, cs_d;
  logic [8:0]  lo_sum;

  always_comb begin
    cs_d   = cs_q;
    lo_sum = {1'b0, cs_q[7:0]} + {1'b0, b};
    if (clr) begin
      cs_d = '0;
    end else if (en) begin
      cs_d[7:0] = lo_sum[7:0];
      // The final byte only touches the low half; the carry is discarded.
      if (!last) cs_d[15:8] = cs_q[15:8] + b + {7'd0, lo_sum[8]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) cs_q <= '0;
    else       cs_q <= cs_d;
  end

  assign cs = cs_q;

endmodule
`endif

// File: rtl/rk_loader.sv
// -----------------------------------------------------------------------------
// rk_loader
// Streaming parser for RKA/RKR/GAM tape images. Strips header and trailer,
// writes payload bytes to their load addresses, checks the RK checksum and
// reports the entry address for autostart.
//   clk_sys, reset : clock, synchronous active-high reset
//   dl_active      : download in progress; a rising edge starts a new file
//   bus (slave)    : in_valid/in_data byte stream, mem_we/mem_addr/mem_din
//   busy           : header..checksum being parsed
//   done           : file accepted (held until next dl_active rise or reset)
//   entry_addr     : start address from the header
//   err_format     : malformed/truncated file (sticky until next rise)
//   err_checksum   : checksum mismatch (sticky until next rise)
// Build option: RK_CHECKSUM_EN enables checksum accumulation and compare;
// without it err_checksum is 0 and the trailer bytes are consumed unchecked.
// -----------------------------------------------------------------------------
module rk_loader
  import apogee_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = RK_SYNC_DEFAULT,
  parameter int         MAX_PAD   = RK_MAX_PAD_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  rk_loader_if.slave  bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] entry_addr,
  output logic        err_format,
  output logic        err_checksum
);

  localparam int PAD_W = $clog2(MAX_PAD + 2);

  rk_state_t         state_q, state_d;
  logic              dl_q;
  logic              sync_seen_q, sync_seen_d;
  logic [15:0]       start_q, start_d;
  logic [15:0]       end_q, end_d;
  logic [15:0]       addr_q, addr_d;
  logic [PAD_W-1:0]  pad_cnt_q, pad_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              done_q, done_d;
  logic [15:0]       entry_q, entry_d;
  logic              err_fmt_q, err_fmt_d;
  logic              dl_rise, dl_fall, is_last;
  logic              cs_clr, cs_en;

`ifdef RK_CHECKSUM_EN
  logic [7:0]  exp_hi_q, exp_hi_d;
  logic        err_cs_q, err_cs_d;
  logic [15:0] cs;

  rk_checksum u_checksum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (cs_clr),
    .en      (cs_en),
    .last    (is_last),
    .b       (bus.in_data),
    .cs      (cs)
  );
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d     = state_q;
    sync_seen_d = sync_seen_q;
    start_d     = start_q;
    end_d       = end_q;
    addr_d      = addr_q;
    pad_cnt_d   = pad_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    done_d      = done_q;
    entry_d     = entry_q;
    err_fmt_d   = err_fmt_q;
    cs_clr      = 1'b0;
    cs_en       = 1'b0;
`ifdef RK_CHECKSUM_EN
    exp_hi_d    = exp_hi_q;
    err_cs_d    = err_cs_q;
`endif

    dl_rise = dl_active & ~dl_q;
    dl_fall = ~dl_active & dl_q;
    is_last = (addr_q == end_q);

    if (dl_rise) begin
      // A new download restarts from any state; a coincident byte is dropped.
      state_d     = HDR0;
      done_d      = 1'b0;
      err_fmt_d   = 1'b0;
      sync_seen_d = 1'b0;
      pad_cnt_d   = '0;
      cs_clr      = 1'b1;
`ifdef RK_CHECKSUM_EN
      err_cs_d    = 1'b0;
`endif
    end else if (dl_fall && busy) begin
      state_d   = ERR;
      err_fmt_d = 1'b1;
    end else if (bus.in_valid) begin
      case (state_q)
        HDR0: begin
          // Only one leading sync byte is skipped; a second one is start_hi.
          if (bus.in_data == SYNC_BYTE && !sync_seen_q) begin
            sync_seen_d = 1'b1;
          end else begin
            start_d = {bus.in_data, start_q[7:0]};
            state_d = HDR1;
          end
        end
        HDR1: begin
          start_d = {start_q[15:8], bus.in_data};
          state_d = HDR2;
        end
        HDR2: begin
          end_d   = {bus.in_data, end_q[7:0]};
          state_d = HDR3;
        end
        HDR3: begin
          end_d = {end_q[15:8], bus.in_data};
          if ({end_q[15:8], bus.in_data} < start_q) begin
            state_d   = ERR;
            err_fmt_d = 1'b1;
          end else begin
            addr_d  = start_q;
            entry_d = start_q;
            state_d = DATA;
          end
        end
        DATA: begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = bus.in_data;
          cs_en      = 1'b1;
          if (is_last) state_d = PAD;
          else         addr_d  = addr_q + 16'd1;
        end
        PAD: begin
          if (bus.in_data == 8'h00) begin
            if (pad_cnt_q == PAD_W'(MAX_PAD)) begin
              state_d   = ERR;
              err_fmt_d = 1'b1;
            end else begin
              pad_cnt_d = pad_cnt_q + 1'b1;
            end
          end else if (bus.in_data == SYNC_BYTE) begin
            state_d = CSH;
          end else begin
            state_d   = ERR;
            err_fmt_d = 1'b1;
          end
        end
        CSH: begin
`ifdef RK_CHECKSUM_EN
          exp_hi_d = bus.in_data;
`endif
          state_d = CSL;
        end
        CSL: begin
`ifdef RK_CHECKSUM_EN
          err_cs_d = (cs != {exp_hi_q, bus.in_data});
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    // Tracks dl_active even during reset so a level held across reset is
    // not mistaken for a fresh download.
    dl_q <= dl_active;
    if (reset) begin
      state_q     <= IDLE;
      sync_seen_q <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      addr_q      <= '0;
      pad_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      done_q      <= 1'b0;
      entry_q     <= '0;
      err_fmt_q   <= 1'b0;
`ifdef RK_CHECKSUM_EN
      exp_hi_q    <= '0;
      err_cs_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_seen_q <= sync_seen_d;
      start_q     <= start_d;
      end_q       <= end_d;
      addr_q      <= addr_d;
      pad_cnt_q   <= pad_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      done_q      <= done_d;
      entry_q     <= entry_d;
      err_fmt_q   <= err_fmt_d;
`ifdef RK_CHECKSUM_EN
      exp_hi_q    <= exp_hi_d;
      err_cs_q    <= err_cs_d;
`endif
    end
  end

  assign busy         = state_q inside {HDR0, HDR1, HDR2, HDR3, DATA, PAD, CSH, CSL};
  assign done         = done_q;
  assign entry_addr   = entry_q;
  assign err_format   = err_fmt_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
`ifdef RK_CHECKSUM_EN
  assign err_checksum = err_cs_q;
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: doc/rk_loader.md
Name: rk_loader

Overview:
- Streaming parser for Radio-86RK / Apogee tape images (RKA, RKR, GAM) delivered byte-by-byte by the HPS download channel.
- Sits upstream of the system RAM write mux. Strips the header and trailer, writes payload bytes to their load addresses, and verifies the RK checksum.
- Reports the entry address so the top level can autostart the program.

Parameters:
- SYNC_BYTE, 8'hE6: sync marker that optionally leads a file (GAM) and precedes the checksum.
- MAX_PAD, 4: maximum number of 8'h00 padding bytes accepted between the payload and the trailer sync.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- dl_active, in, 1: download in progress (level).
- in_valid, in, 1: one-cycle strobe, in_data valid.
- in_data, in, 8: file byte.
- mem_we, out, 1: one-cycle RAM write strobe.
- mem_addr, out, 16: RAM write address.
- mem_din, out, 8: RAM write data.
- busy, out, 1: parse in progress.
- done, out, 1: file accepted; level, held until the next dl_active rise or reset.
- entry_addr, out, 16: start address from the header.
- err_format, out, 1: malformed or truncated file; sticky until the next dl_active rise.
- err_checksum, out, 1: checksum mismatch; sticky until the next dl_active rise.

Behaviour:
- Reset values:
  - All outputs 0; entry_addr = 16'h0000; state IDLE.
  - Reset mid-file aborts parsing with no further writes.
- Starting a file:
  - A dl_active rising edge (registered edge detect) → clear done/err flags, reset the checksum, go to HDR0. Applies from any state, which restarts any in-progress parse.
- States and transitions:
  - IDLE → HDR0: on dl_active rise.
  - HDR0: first byte == SYNC_BYTE → discard and stay in HDR0 (once only; a second E6 is treated as the start-address hi byte). Otherwise latch start_hi → HDR1.
  - HDR1: start_lo → HDR2.
  - HDR2: end_hi → HDR3.
  - HDR3: end_lo. If end < start (unsigned) → ERR with err_format=1. Otherwise set addr = start, entry_addr = start → DATA.
  - DATA: each in_valid → mem_we pulses on the next cycle with mem_addr = addr and mem_din = byte, and the byte is folded into the checksum. If addr == end → PAD; else addr += 1 (16-bit, no wrap possible since end ≥ start).
  - PAD:
    - 8'h00 → pad count += 1; count > MAX_PAD → ERR.
    - SYNC_BYTE → CSH.
    - Any other byte → ERR.
  - CSH: latch expected checksum hi → CSL.
  - CSL: latch expected lo; compare; done=1; err_checksum = mismatch → DONE.
  - DONE / ERR: ignore all further bytes until the next dl_active rise.
- Truncation:
  - dl_active falls in HDR*, DATA, PAD or CSH → ERR with err_format=1.
  - dl_active falls in CSL → also ERR (the trailer is incomplete).
- busy = state in {HDR0..CSL}.
- Checksum (RK algorithm):
  - 16-bit cs = 0 at the start.
  - For every payload byte except the last: {carry, lo} = lo + b; hi = hi + b + carry.
  - For the last payload byte (addr == end): lo = lo + b only.
  - Single-byte file (start == end): only the last-byte rule is applied.
- Simultaneous in_valid and dl_active rise: the rise wins and the byte is dropped.
- Throughput: one byte per clk_sys cycle sustained. mem_we latency is exactly 1 cycle after in_valid.

Optional Feature:
- RK_CHECKSUM_EN:
  - Defined: full checksum accumulation and compare as above.
  - Undefined: accumulator and compare are removed; err_checksum is tied 0; the CSH/CSL bytes are consumed but not checked; done is still set after CSL.

Decomposition:
- apogee_pkg:
  - rk_state_t enum: IDLE, HDR0, HDR1, HDR2, HDR3, DATA, PAD, CSH, CSL, DONE, ERR.
  - Constants RK_SYNC_DEFAULT = 8'hE6 and RK_HDR_LEN = 4.
- Sub-module rk_checksum (clk_sys, reset, clr, en, last, b → cs[15:0]), instantiated only under RK_CHECKSUM_EN.

Test Plan:
- Basic file. Bytes 00 00 00 02 01 02 03 00 E6 03 06 → writes (0000,01), (0001,02), (0002,03); done=1; errs=0; entry_addr=0000.
- GAM prefix and bad checksum. Bytes E6 10 00 10 00 AA E6 00 AA, with checksum corrupted to 00 AB → one write (1000,AA); err_checksum=1; done=1.
- End below start. Header 20 00 1F FF → ERR; err_format=1; no mem_we.
- Truncation. dl_active drops after 2 of 5 payload bytes → exactly 2 writes; err_format=1; busy=0.
- Restart mid-file. dl_active falls and rises during DATA, then a valid file follows → flags cleared; the new file loads correctly; stale addresses are not written.
- Padding limit. 5 × 00 after the payload with MAX_PAD=4 → err_format=1. With RK_CHECKSUM_EN undefined, the basic file with a wrong checksum → done=1, err_checksum=0.
